// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake status.
package cpu_types_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the unified memory port arbiter.
interface mem_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = 32
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    ramstate_t         ramstate;

    // Arbiter side.
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Requesters and RAM side.
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of data grants completed while a fetch waits.
module starve_counter #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign sat = (cnt == MAX_V);

    // Clear wins over increment.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter: data requester has priority, fetch is forced
// ahead after STARVE_MAX consecutive data completions.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    arb_state_t state, next_state;

    logic       dreq;
    logic       d_done;
    logic       i_done;
    logic       starve_sat;
    logic [3:0] starve_cnt;

    assign dreq = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        d_done       = 1'b0;
        i_done       = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = bus.ramload[WORD_W-1:0];
        bus.dload    = bus.ramload[WORD_W-1:0];

        unique case (state)
            IDLE: begin
                if (dreq && !(bus.iREN && starve_sat)) begin
                    next_state = DGRANT;
                end else if (bus.iREN) begin
                    next_state = IGRANT;
                end
            end
            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                // A withdrawn request never acks, even if RAM reports ACCESS.
                if (!dreq) begin
                    next_state = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dwait  = 1'b0;
                    d_done     = 1'b1;
                    next_state = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    next_state = IDLE;
                end
            end
            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    next_state = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.iwait  = 1'b0;
                    i_done     = 1'b1;
                    next_state = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Increment only matters while iREN is high; iREN low clears.
    starve_counter #(
        .MAX (STARVE_MAX),
        .W   (4)
    ) u_starve (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (~bus.iREN | i_done),
        .inc  (d_done),
        .cnt  (starve_cnt),
        .sat  (starve_sat)
    );

    logic unused_cnt;
    assign unused_cnt = ^starve_cnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int SMAX = 4;

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   failures = 0;

    // Model: who owns the RAM port (0 none, 1 data, 2 fetch) and starvation count.
    int m_owner = 0;
    int m_starve = 0;

    mem_arbiter_if #(.WORD_W(32)) bus ();

    mem_arbiter #(
        .WORD_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        logic        dq;
        dq = bus.dREN | bus.dWEN;
        e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = 0; e_store = 0;
        if (nRST && m_owner == 1) begin
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN & ~bus.dWEN;
            e_dw    = !(dq && bus.ramstate == ACCESS);
        end else if (nRST && m_owner == 2) begin
            e_addr = bus.iaddr;
            e_ren  = bus.iREN;
            e_iw   = !(bus.iREN && bus.ramstate == ACCESS);
        end
        chk("ramREN", bus.ramREN, e_ren);
        chk("ramWEN", bus.ramWEN, e_wen);
        chk("ramaddr", bus.ramaddr, e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("iwait", bus.iwait, e_iw);
        chk("dwait", bus.dwait, e_dw);
        chk("iload", bus.iload, bus.ramload);
        chk("dload", bus.dload, bus.ramload);
        chk("wait_excl", bus.iwait | bus.dwait, 1);
    endtask

    task automatic model_step();
        logic dq, done_d, done_i;
        int   nxt;
        if (!nRST) begin
            m_owner = 0;
            m_starve = 0;
            return;
        end
        dq     = bus.dREN | bus.dWEN;
        done_d = (m_owner == 1) && dq && bus.ramstate == ACCESS;
        done_i = (m_owner == 2) && bus.iREN && bus.ramstate == ACCESS;
        nxt = m_owner;
        if (m_owner == 0) begin
            if (dq && !(bus.iREN && m_starve == SMAX)) nxt = 1;
            else if (bus.iREN) nxt = 2;
        end else begin
            if (!(m_owner == 1 ? dq : bus.iREN) ||
                bus.ramstate == ACCESS || bus.ramstate == ERROR) nxt = 0;
        end
        if (!bus.iREN || done_i) m_starve = 0;
        else if (done_d && m_starve < SMAX) m_starve = m_starve + 1;
        m_owner = nxt;
    endtask

    task automatic settle();
        #2;
        model_check();
    endtask

    task automatic adv();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.ramstate = FREE;
    endtask

    initial begin
        int dacks, iacks, first_i, dacks_at_i;
        nRST = 0;
        bus.iaddr = 32'h0; bus.daddr = 32'h44; bus.dstore = 32'h0;
        bus.ramload = 32'h1234_5678;
        bus.iREN = 1; bus.dREN = 1; bus.dWEN = 0; bus.ramstate = ACCESS;

        // Reset held with both requests pending.
        @(negedge CLK);
        settle();
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_iwait", bus.iwait, 1);
        chk("rst_dwait", bus.dwait, 1);
        adv();
        nRST = 1;
        settle();
        chk("post_rst_idle", bus.ramREN, 0);
        adv();
        settle();
        chk("post_rst_dgrant_ren", bus.ramREN, 1);
        chk("post_rst_dgrant_addr", bus.ramaddr, 32'h44);
        adv();
        idle_inputs();
        settle(); adv();
        settle(); adv();

        // Single fetch with two BUSY cycles.
        bus.iREN = 1; bus.iaddr = 32'h40;
        settle(); adv();
        bus.ramstate = BUSY;
        settle();
        chk("fetch_c1_addr", bus.ramaddr, 32'h40);
        chk("fetch_c1_iwait", bus.iwait, 1);
        adv();
        settle();
        chk("fetch_c2_addr", bus.ramaddr, 32'h40);
        chk("fetch_c2_iwait", bus.iwait, 1);
        adv();
        bus.ramstate = ACCESS; bus.ramload = 32'h8C01_0004;
        settle();
        chk("fetch_c3_addr", bus.ramaddr, 32'h40);
        chk("fetch_c3_iwait", bus.iwait, 0);
        chk("fetch_iload", bus.iload, 32'h8C01_0004);
        adv();
        idle_inputs();
        settle();
        chk("fetch_c4_iwait", bus.iwait, 1);
        adv();

        // Data write, RAM ready immediately.
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
        bus.ramstate = ACCESS;
        settle(); adv();
        settle();
        chk("wr_ramWEN", bus.ramWEN, 1);
        chk("wr_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        chk("wr_dwait", bus.dwait, 0);
        adv();
        bus.dWEN = 0;
        settle();
        chk("wr_back_idle", bus.ramWEN, 0);
        adv();

        // Contention: fetch forced ahead after SMAX data completions.
        bus.iREN = 1; bus.iaddr = 32'h300; bus.dREN = 1; bus.daddr = 32'h200;
        bus.ramstate = ACCESS;
        dacks = 0; iacks = 0; first_i = -1; dacks_at_i = -1;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (!bus.dwait) dacks++;
            if (!bus.iwait) begin
                iacks++;
                if (first_i < 0) begin
                    first_i = c;
                    dacks_at_i = dacks;
                end
            end
            if (c == 8) chk("model_starve_max", m_starve, SMAX);
            if (c == 10) chk("model_starve_clr", m_starve, 0);
            if (c == 11) chk("cont_d_after_i", bus.dwait, 0);
            adv();
        end
        chk("cont_dacks_before_i", dacks_at_i, SMAX);
        chk("cont_first_i_cycle", first_i, 9);
        chk("cont_iacks", iacks, 1);
        idle_inputs();
        settle(); adv();

        // ERROR then retry.
        bus.dREN = 1; bus.daddr = 32'h80; bus.ramstate = ERROR;
        settle(); adv();
        settle();
        chk("err_dwait", bus.dwait, 1);
        chk("err_ramREN", bus.ramREN, 1);
        adv();
        settle();
        chk("err_idle", bus.ramREN, 0);
        adv();
        bus.ramstate = ACCESS;
        settle();
        chk("retry_dwait", bus.dwait, 0);
        adv();
        idle_inputs();
        settle(); adv();

        // Fetch withdrawn mid-grant.
        bus.iREN = 1; bus.iaddr = 32'h50; bus.ramstate = BUSY;
        settle(); adv();
        settle();
        chk("wd_grant_ren", bus.ramREN, 1);
        adv();
        bus.iREN = 0; bus.ramstate = ACCESS;
        settle();
        chk("wd_no_ack", bus.iwait, 1);
        adv();
        bus.iREN = 1;
        settle();
        chk("wd_went_idle", bus.iwait, 1);
        adv();
        settle();
        chk("wd_reissue_ack", bus.iwait, 0);
        adv();
        idle_inputs();
        settle(); adv();

        // Asynchronous reset in the middle of a data grant.
        bus.dREN = 1; bus.daddr = 32'h90; bus.ramstate = BUSY;
        settle(); adv();
        settle();
        chk("mr_grant_ren", bus.ramREN, 1);
        #1 nRST = 0;
        #1;
        chk("mr_async_ren", bus.ramREN, 0);
        chk("mr_async_dwait", bus.dwait, 1);
        m_owner = 0; m_starve = 0;
        adv();
        nRST = 1;
        idle_inputs();
        settle(); adv();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            int r;
            bus.iREN = ($urandom_range(0, 99) < 60);
            r = $urandom_range(0, 9);
            bus.dREN = (r < 3) || (r == 9);
            bus.dWEN = (r >= 3 && r < 6) || (r == 9);
            bus.iaddr = $urandom; bus.daddr = $urandom;
            bus.dstore = $urandom; bus.ramload = $urandom;
            r = $urandom_range(0, 9);
            bus.ramstate = (r < 2) ? FREE : (r < 5) ? BUSY : (r < 9) ? ACCESS : ERROR;
            settle();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
